// File: rtl/input_cmd_decoder_if.sv
// input_cmd_decoder_if: FIFO pop port plus command handshake between decoder and game logic
//   poll_enable            permits new pops
//   pop_req / pop_data     one-cycle pop strobe to the FIFO, button vector returned by it
//   cmd_valid / cmd_ready  command handshake
//   cmd_code / cmd_buttons / cmd_multi  decoded command payload
//   event_count            accepted-command counter
interface input_cmd_decoder_if;
  logic       poll_enable;
  logic       pop_req;
  logic [3:0] pop_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic [3:0] cmd_buttons;
  logic       cmd_multi;
  logic [7:0] event_count;
  modport master (
    input  poll_enable, pop_data, cmd_ready,
    output pop_req, cmd_valid, cmd_code, cmd_buttons, cmd_multi, event_count
  );
  modport slave (
    output poll_enable, pop_data, cmd_ready,
    input  pop_req, cmd_valid, cmd_code, cmd_buttons, cmd_multi, event_count
  );
endinterface

// File: rtl/input_cmd_decoder.sv
// input_cmd_decoder: periodically pops the button FIFO and presents non-empty vectors as priority-encoded commands
//   sys_clock  system clock, rising edge
//   reset      asynchronous active-high reset
//   bus        input_cmd_decoder_if.master: pop port toward the FIFO, command handshake toward game logic
module input_cmd_decoder #(
  parameter int POLL_DIV   = 1000,
  parameter int RD_LATENCY = 1
) (
  input logic                 sys_clock,
  input logic                 reset,
  input_cmd_decoder_if.master bus
);
  localparam int TW = $clog2(POLL_DIV + 1);
  localparam int WW = $clog2(RD_LATENCY + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(POLL_DIV - 1);
  localparam logic [WW-1:0] W_LAST = WW'(RD_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, POP, WAIT, SAMPLE, HOLD} state_t;
  state_t state, next;
  logic [TW-1:0] timer;
  logic [WW-1:0] wait_cnt;
  logic          valid, multi, accept, wait_done, pd_multi;
  logic [2:0]    code, pd_code;
  logic [3:0]    buttons;
  logic [7:0]    count;
  // The read data is captured at the end of the last WAIT cycle, so SAMPLE is
  // already the first cycle the command is offered; an immediate accept there
  // skips HOLD entirely and an empty read simply returns to IDLE.
  always_comb begin
    accept    = valid && bus.cmd_ready;
    wait_done = wait_cnt == W_LAST;
    pd_code   = bus.pop_data[0] ? 3'd1 : bus.pop_data[1] ? 3'd2 :
                bus.pop_data[2] ? 3'd3 : bus.pop_data[3] ? 3'd4 : 3'd0;
    pd_multi  = (bus.pop_data & (bus.pop_data - 4'd1)) != 4'd0;
    next      = (state == IDLE)   ? ((timer == '0 && bus.poll_enable) ? POP : IDLE) :
                (state == POP)    ? WAIT :
                (state == WAIT)   ? (wait_done ? SAMPLE : WAIT) :
                (state == SAMPLE) ? ((!valid || accept) ? IDLE : HOLD) :
                (accept ? IDLE : HOLD);
  end
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= T_LOAD;
      wait_cnt <= '0;
      valid    <= 1'b0;
      code     <= 3'd0;
      buttons  <= 4'd0;
      multi    <= 1'b0;
      count    <= 8'd0;
    end else begin
      state    <= next;
      timer    <= (state != IDLE && next == IDLE) ? T_LOAD :
                  (state == IDLE && timer != '0) ? timer - TW'(1) : timer;
      wait_cnt <= (state == WAIT) ? wait_cnt + WW'(1) : '0;
      if (state == WAIT && wait_done) begin
        buttons <= bus.pop_data;
        code    <= pd_code;
        multi   <= pd_multi;
        valid   <= |bus.pop_data;
      end else if (accept) begin
        valid <= 1'b0;
      end
      if (accept) count <= count + 8'd1;
    end
  end
  assign bus.pop_req     = state == POP;
  assign bus.cmd_valid   = valid;
  assign bus.cmd_code    = code;
  assign bus.cmd_buttons = buttons;
  assign bus.cmd_multi   = multi;
  assign bus.event_count = count;
endmodule

// File: tb/tb_input_cmd_decoder.sv
// tb_input_cmd_decoder: table vectors, corner sequences and a randomized reference-model run
module tb_input_cmd_decoder;
  localparam int POLL_DIV = 4;
  localparam int RD_LAT   = 1;
  logic sys_clock = 1'b0;
  logic reset = 1'b1;
  input_cmd_decoder_if bus();
  input_cmd_decoder #(.POLL_DIV(POLL_DIV), .RD_LATENCY(RD_LAT)) dut (
    .sys_clock(sys_clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 sys_clock = ~sys_clock;
  typedef struct {
    logic [3:0] vec;
    int         stall;
    logic [2:0] code;
    logic       multi;
  } vec_t;
  vec_t tbl[9];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_pop_cyc = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(negedge sys_clock);
    cyc++;
  endtask

  function automatic logic [2:0] ref_code(input logic [3:0] v);
    ref_code = 3'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) ref_code = 3'(i + 1);
  endfunction

  function automatic logic ref_multi(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n > 1;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_pop_req"}, 32'(bus.pop_req), 0);
    chk({tag, "_valid"}, 32'(bus.cmd_valid), 0);
    chk({tag, "_code"}, 32'(bus.cmd_code), 0);
    chk({tag, "_buttons"}, 32'(bus.cmd_buttons), 0);
    chk({tag, "_multi"}, 32'(bus.cmd_multi), 0);
    chk({tag, "_count"}, 32'(bus.event_count), 0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.cmd_ready = 1'b0;
    bus.pop_data = 4'd0;
    @(negedge sys_clock);
    @(negedge sys_clock);
    chk_zero_outputs("reset");
    reset = 1'b0;
    cyc = 0;
    exp_pop_cyc = POLL_DIV;
    exp_count = 8'd0;
  endtask

  task automatic wait_pop;
    int g = 0;
    while (bus.pop_req !== 1'b1 && g < 100) begin
      tick;
      g++;
    end
    chk("pop_seen", 32'(bus.pop_req), 1);
  endtask

  // One full transaction: pop timing, read latency, payload, stall stability, acceptance.
  task automatic run_txn(input logic [3:0] v, input int stall, input logic [2:0] code, input logic multi);
    bus.pop_data = v;
    bus.cmd_ready = 1'b0;
    wait_pop;
    if (bus.pop_req !== 1'b1) return;
    chk("pop_cycle", 32'(cyc), 32'(exp_pop_cyc));
    for (int i = 0; i <= RD_LAT; i++) begin
      tick;
      chk("pop_once", 32'(bus.pop_req), 0);
      if (i < RD_LAT) chk("valid_early", 32'(bus.cmd_valid), 0);
    end
    if (v == 4'd0) begin
      chk("valid_empty", 32'(bus.cmd_valid), 0);
      chk("count_empty", 32'(bus.event_count), 32'(exp_count));
      exp_pop_cyc = cyc + 1 + POLL_DIV;
    end else begin
      for (int k = 0; k <= stall; k++) begin
        chk("valid_hold", 32'(bus.cmd_valid), 1);
        chk("code", 32'(bus.cmd_code), 32'(code));
        chk("buttons", 32'(bus.cmd_buttons), 32'(v));
        chk("multi", 32'(bus.cmd_multi), 32'(multi));
        chk("pop_stall", 32'(bus.pop_req), 0);
        chk("count_hold", 32'(bus.event_count), 32'(exp_count));
        if (k == stall) bus.cmd_ready = 1'b1;
        tick;
      end
      exp_count++;
      chk("valid_drop", 32'(bus.cmd_valid), 0);
      chk("count_inc", 32'(bus.event_count), 32'(exp_count));
      bus.cmd_ready = 1'b0;
      exp_pop_cyc = cyc + POLL_DIV;
    end
  endtask

  // Event-level model: tracks IDLE entry, pop cycle, capture cycle and acceptance cycle.
  task automatic rand_phase(input int n);
    bit busy = 0;
    bit have = 0;
    int idle_from = 0;
    int pop_at = -1;
    int vfrom = 0;
    int end_at = -1;
    logic [3:0] mv = 4'd0;
    logic [7:0] mc = 8'd0;
    for (int c = 0; c < n; c++) begin
      chk("r_pop", 32'(bus.pop_req), 32'(busy && c == pop_at));
      chk("r_valid", 32'(bus.cmd_valid), 32'(have && c >= vfrom));
      if (have && c >= vfrom) begin
        chk("r_code", 32'(bus.cmd_code), 32'(ref_code(mv)));
        chk("r_buttons", 32'(bus.cmd_buttons), 32'(mv));
        chk("r_multi", 32'(bus.cmd_multi), 32'(ref_multi(mv)));
      end
      chk("r_count", 32'(bus.event_count), 32'(mc));
      bus.poll_enable = $urandom_range(0, 4) != 0;
      bus.cmd_ready = 1'($urandom_range(0, 1));
      bus.pop_data = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if (!busy) begin
        if (c >= idle_from + POLL_DIV - 1 && bus.poll_enable) begin
          busy = 1;
          pop_at = c + 1;
        end
      end else begin
        if (c == pop_at + RD_LAT) begin
          mv = bus.pop_data;
          have = mv != 4'd0;
          vfrom = c + 1;
          if (!have) end_at = c + 1;
        end
        if (have && c >= vfrom && bus.cmd_ready) begin
          mc++;
          have = 0;
          end_at = c;
        end
        if (c == end_at) begin
          busy = 0;
          idle_from = c + 1;
        end
      end
      tick;
    end
  endtask

  initial begin
    logic [3:0] v;
    tbl[0] = '{4'b0000, 0, 3'd0, 1'b0};
    tbl[1] = '{4'b0000, 0, 3'd0, 1'b0};
    tbl[2] = '{4'b0100, 0, 3'd3, 1'b0};
    tbl[3] = '{4'b1010, 20, 3'd2, 1'b1};
    tbl[4] = '{4'b1000, 2, 3'd4, 1'b0};
    tbl[5] = '{4'b0001, 0, 3'd1, 1'b0};
    tbl[6] = '{4'b1111, 1, 3'd1, 1'b1};
    tbl[7] = '{4'b0110, 3, 3'd2, 1'b1};
    tbl[8] = '{4'b0000, 0, 3'd0, 1'b0};
    bus.poll_enable = 1'b1;
    bus.cmd_ready = 1'b0;
    bus.pop_data = 4'd0;
    do_reset;
    for (int i = 0; i < 9; i++) run_txn(tbl[i].vec, tbl[i].stall, tbl[i].code, tbl[i].multi);
    // poll_enable low after reset: no pops until it rises
    bus.poll_enable = 1'b0;
    do_reset;
    for (int i = 0; i < 50; i++) begin
      chk("pop_disabled", 32'(bus.pop_req), 0);
      tick;
    end
    bus.poll_enable = 1'b1;
    exp_pop_cyc = cyc + 1;
    run_txn(4'b0001, 0, 3'd1, 1'b0);
    // reset while holding a code-4 command
    bus.pop_data = 4'b1000;
    bus.cmd_ready = 1'b0;
    wait_pop;
    for (int i = 0; i < RD_LAT + 4; i++) tick;
    chk("hold_valid", 32'(bus.cmd_valid), 1);
    chk("hold_code", 32'(bus.cmd_code), 4);
    reset = 1'b1;
    #1;
    chk_zero_outputs("async");
    @(negedge sys_clock);
    reset = 1'b0;
    cyc = 0;
    exp_pop_cyc = POLL_DIV;
    exp_count = 8'd0;
    run_txn(4'b0000, 0, 3'd0, 1'b0);
    // 256 accepted commands wrap the counter
    for (int i = 0; i < 256; i++) begin
      v = 4'($urandom_range(1, 15));
      run_txn(v, 0, ref_code(v), ref_multi(v));
    end
    chk("wrap", 32'(bus.event_count), 0);
    bus.poll_enable = 1'b1;
    do_reset;
    rand_phase(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
